branch_resolve_unit: RTL and testbench

- Execute-stage branch resolution unit with one registered output stage.
- Computes branch targets in three addressing modes and compares the result against the fetch-stage prediction.
- Raises a redirect on mispredict and trains a direct-mapped branch target buffer (BTB) that fetch reads combinationally.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/branch_resolve_unit_if.sv | 44 ++++
 rtl/branch_btb.sv | 60 ++++++
 rtl/branch_resolve_unit.sv | 118 +++++++++++
 tb/tb_branch_resolve_unit.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolve unit.
// Optional feature macro: BRU_PERF_CNT_EN (branch / mispredict counters).
package branch_pkg;

  // Target addressing modes; MODE_RSVD resolves like PC_REL.
  typedef enum logic [1:0] {
    PC_REL    = 2'd0,
    REG_REL   = 2'd1,
    REG_ALIGN = 2'd2,
    MODE_RSVD = 2'd3
  } addr_mode_t;

  // Fall-through distance to the next sequential instruction.
  localparam int INSTR_BYTES = 4;

  // Saturating increment for 32-bit event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response and BTB lookup bundle of the branch resolve unit.
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// && !flush; a result transfers where out_valid && out_ready. in_ready is
// combinational (!out_valid || out_ready) and results hold while stalled.
interface branch_resolve_unit_if #(
  parameter int WordSize = 32
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WordSize-1:0] pc;
  logic [WordSize-1:0] imm;
  logic [WordSize-1:0] rs1d;
  logic [1:0]          addr_mode;
  logic                is_branch;
  logic                branch_taken;
  logic                pred_taken;
  logic [WordSize-1:0] pred_target;
  logic                out_valid;
  logic                out_ready;
  logic [WordSize-1:0] branch_addr;
  logic [WordSize-1:0] npc;
  logic                mispredict;
  logic                redirect;
  logic [WordSize-1:0] fetch_pc;
  logic                btb_hit;
  logic [WordSize-1:0] btb_target;

  // Execute pipeline / fetch side.
  modport master (
    output flush, in_valid, pc, imm, rs1d, addr_mode, is_branch, branch_taken,
           pred_taken, pred_target, out_ready, fetch_pc,
    input  in_ready, out_valid, branch_addr, npc, mispredict, redirect,
           btb_hit, btb_target
  );

  // The resolve unit itself.
  modport slave (
    input  flush, in_valid, pc, imm, rs1d, addr_mode, is_branch, branch_taken,
           pred_taken, pred_target, out_ready, fetch_pc,
    output in_ready, out_valid, branch_addr, npc, mispredict, redirect,
           btb_hit, btb_target
  );
endinterface

// File: rtl/branch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one write port,
// synchronous clear. A same-cycle read of the written index sees old data.
module branch_btb
  import branch_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int BtbDepth = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [WordSize-1:0] wr_pc,
  input  logic [WordSize-1:0] wr_target,
  input  logic [WordSize-1:0] rd_pc,
  output logic                rd_hit,
  output logic [WordSize-1:0] rd_target
);
  localparam int IdxBits = $clog2(BtbDepth);
  localparam int TagBits = WordSize - IdxBits - 2;

  typedef struct packed {
    logic                valid;
    logic [TagBits-1:0]  tag;
    logic [WordSize-1:0] target;
  } btb_entry_t;

  btb_entry_t entry_q [BtbDepth];

  logic [IdxBits-1:0] wr_idx;
  logic [IdxBits-1:0] rd_idx;
  logic [TagBits-1:0] rd_tag;
  btb_entry_t         rd_entry;

  assign wr_idx = wr_pc[IdxBits+1:2];
  assign rd_idx = rd_pc[IdxBits+1:2];
  assign rd_tag = rd_pc[WordSize-1:IdxBits+2];

  // Instructions are word aligned, so the byte offset never selects an entry.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  // Clear every entry on reset, otherwise install a taken-branch target.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BtbDepth; i++) begin
        entry_q[i] <= '0;
      end
    end else if (wr_en) begin
      entry_q[wr_idx] <= '{valid: 1'b1, tag: wr_pc[WordSize-1:IdxBits+2], target: wr_target};
    end
  end

  // Lookup: hit needs a valid entry whose tag matches; target reads 0 on miss.
  always_comb begin
    rd_entry  = entry_q[rd_idx];
    rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
    rd_target = rd_hit ? rd_entry.target : '0;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: target calculation, next-PC selection,
// mispredict detection, one registered output stage and BTB training.
// Optional macro BRU_PERF_CNT_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int BtbDepth = 8
) (
  input  logic        clk,
  input  logic        rstn,
  branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
`endif
);
  logic                in_ready;
  logic                accept;
  addr_mode_t          mode;
  logic [WordSize-1:0] sum_pc;
  logic [WordSize-1:0] sum_rs;
  logic [WordSize-1:0] target_d;
  logic [WordSize-1:0] npc_d;
  logic                mispredict_d;

  logic                out_valid_q;
  logic [WordSize-1:0] branch_addr_q;
  logic [WordSize-1:0] npc_q;
  logic                mispredict_q;

  logic                btb_hit;
  logic [WordSize-1:0] btb_target;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Resolve the target, next PC and mispredict for the current request.
  always_comb begin
    mode     = addr_mode_t'(bus.addr_mode);
    sum_pc   = bus.pc + bus.imm;
    sum_rs   = bus.rs1d + bus.imm;
    target_d = sum_pc;
    case (mode)
      REG_REL:   target_d = sum_rs;
      REG_ALIGN: target_d = {sum_rs[WordSize-1:1], 1'b0};
      default:   target_d = sum_pc;
    endcase
    npc_d = (bus.is_branch && bus.branch_taken) ? target_d
                                                : bus.pc + WordSize'(INSTR_BYTES);
    mispredict_d = bus.is_branch &&
                   ((bus.pred_taken != bus.branch_taken) ||
                    (bus.branch_taken && (bus.pred_target != target_d)));
  end

  // Output stage: load on accept, drain on out_ready, flush kills it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q   <= 1'b0;
      branch_addr_q <= '0;
      npc_q         <= '0;
      mispredict_q  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      branch_addr_q <= target_d;
      npc_q         <= npc_d;
      mispredict_q  <= mispredict_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  branch_btb #(
    .WordSize (WordSize),
    .BtbDepth (BtbDepth)
  ) u_btb (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (accept && bus.is_branch && bus.branch_taken),
    .wr_pc     (bus.pc),
    .wr_target (target_d),
    .rd_pc     (bus.fetch_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target)
  );

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.branch_addr = branch_addr_q;
  assign bus.npc         = npc_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect    = out_valid_q && mispredict_q;
  assign bus.btb_hit     = btb_hit;
  assign bus.btb_target  = btb_target;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  // Count accepted branches and accepted mispredicts, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (accept) begin
      if (bus.is_branch) branch_cnt_q <= sat_inc32(branch_cnt_q);
      if (mispredict_d)  mispredict_cnt_q <= sat_inc32(mispredict_cnt_q);
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// a randomized run scored against a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int IDXB  = 3;
  localparam int RW    = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WordSize(W)) bus();

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
`endif

  branch_resolve_unit #(
    .WordSize (W),
    .BtbDepth (DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef BRU_PERF_CNT_EN
    ,
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // BTB model: slot number -> last taken-branch pc and its target.
  logic [W-1:0] m_btb_pc  [int];
  logic [W-1:0] m_btb_tgt [int];
  // Scoreboard: {mispredict, npc, branch_addr} of results not yet consumed.
  logic [RW-1:0] exp_q [$];

  function automatic int slot_of(input logic [W-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [W:0] m_lookup(input logic [W-1:0] a);
    int k = slot_of(a);
    if (m_btb_pc.exists(k) && ((m_btb_pc[k] >> (IDXB + 2)) == (a >> (IDXB + 2))))
      return {1'b1, m_btb_tgt[k]};
    return {1'b0, {W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] m_target(input logic [W-1:0] pc, imm, rs1d,
                                            input logic [1:0] mode);
    logic [W-1:0] s;
    if (mode == 2'd1) s = rs1d + imm;
    else if (mode == 2'd2) s = ((rs1d + imm) / 2) * 2;
    else s = pc + imm;
    return s;
  endfunction

  // Expected result for whatever request is currently on the bus inputs.
  function automatic logic [RW-1:0] m_result_bus();
    logic [W-1:0] t, n;
    logic m;
    t = m_target(bus.pc, bus.imm, bus.rs1d, bus.addr_mode);
    n = (bus.is_branch && bus.branch_taken) ? t : bus.pc + 4;
    m = bus.is_branch && ((bus.pred_taken != bus.branch_taken) ||
                          (bus.branch_taken && (bus.pred_target != t)));
    return {m, n, t};
  endfunction

  // Record the BTB effect of accepting the request on the bus.
  task automatic m_commit();
    if (bus.is_branch && bus.branch_taken) begin
      m_btb_pc[slot_of(bus.pc)]  = bus.pc;
      m_btb_tgt[slot_of(bus.pc)] = m_target(bus.pc, bus.imm, bus.rs1d, bus.addr_mode);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.pc = '0; bus.imm = '0; bus.rs1d = '0; bus.addr_mode = 2'd0;
    bus.is_branch = 1'b0; bus.branch_taken = 1'b0; bus.pred_taken = 1'b0;
    bus.pred_target = '0; bus.fetch_pc = '0;
  endtask

  task automatic drive_req(input logic [W-1:0] pc, imm, rs1d, input logic [1:0] mode,
                           input logic isb, tk, pt, input logic [W-1:0] ptgt);
    bus.pc = pc; bus.imm = imm; bus.rs1d = rs1d; bus.addr_mode = mode;
    bus.is_branch = isb; bus.branch_taken = tk; bus.pred_taken = pt;
    bus.pred_target = ptgt; bus.in_valid = 1'b1;
  endtask

  task automatic rand_fields();
    logic [W-1:0] imm;
    case ($urandom_range(0, 3))
      0: imm = W'($urandom_range(0, 255)) * 4;
      1: imm = -(W'($urandom_range(1, 64)) * 4);
      2: imm = $urandom;
      default: imm = '0;
    endcase
    bus.pc = 32'h4000 + W'($urandom_range(0, 47)) * 4;
    bus.imm = imm;
    bus.rs1d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + W'($urandom_range(0, 15)) : $urandom;
    bus.addr_mode = 2'($urandom_range(0, 3));
    bus.is_branch = ($urandom_range(0, 3) != 0);
    bus.branch_taken = $urandom_range(0, 1) == 1;
    bus.pred_taken = $urandom_range(0, 1) == 1;
    bus.pred_target = ($urandom_range(0, 1) == 1) ?
        m_target(bus.pc, bus.imm, bus.rs1d, bus.addr_mode) : $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    bus.fetch_pc = 32'h100;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    m_btb_pc.delete(); m_btb_tgt.delete(); exp_q.delete();
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.npc !== 32'h0) begin bad++; $display("FAIL reset_npc: got %h want 0", bus.npc); end
    total++; if (bus.branch_addr !== 32'h0) begin bad++; $display("FAIL reset_branch_addr: got %h want 0", bus.branch_addr); end
    total++; if (bus.mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict: got %b want 0", bus.mispredict); end
    total++; if (bus.btb_hit !== 1'b0) begin bad++; $display("FAIL reset_btb_hit: got %b want 0", bus.btb_hit); end
    total++; if (bus.btb_target !== 32'h0) begin bad++; $display("FAIL reset_btb_target: got %h want 0", bus.btb_target); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_pc_rel();
    drive_req(32'h1000, 32'h20, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h1020);
    m_commit();
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pcrel_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.branch_addr !== 32'h1020) begin bad++; $display("FAIL pcrel_addr: got %h want 1020", bus.branch_addr); end
    total++; if (bus.npc !== 32'h1020) begin bad++; $display("FAIL pcrel_npc: got %h want 1020", bus.npc); end
    total++; if (bus.mispredict !== 1'b0 || bus.redirect !== 1'b0) begin bad++; $display("FAIL pcrel_misp: got %b/%b want 0/0", bus.mispredict, bus.redirect); end
    tick();
    bus.fetch_pc = 32'h1000;
    #1;
    total++; if (bus.btb_hit !== 1'b1 || bus.btb_target !== 32'h1020) begin bad++; $display("FAIL pcrel_btb: got %b/%h want 1/1020", bus.btb_hit, bus.btb_target); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pcrel_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reg_align_wrap();
    drive_req(32'h1100, 32'h4, 32'hFFFF_FFFF, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0);
    m_commit();
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.branch_addr !== 32'h2) begin bad++; $display("FAIL align_addr: got %h want 2", bus.branch_addr); end
    total++; if (bus.npc !== 32'h2) begin bad++; $display("FAIL align_npc: got %h want 2", bus.npc); end
    total++; if (bus.mispredict !== 1'b1 || bus.redirect !== 1'b1) begin bad++; $display("FAIL align_misp: got %b/%b want 1/1", bus.mispredict, bus.redirect); end
    tick();
  endtask

  task automatic test_not_taken();
    drive_req(32'h2000, 32'h40, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h2040);
    m_commit();
    tick();
    drive_req(32'h2000, 32'h40, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h2040);
    m_commit();
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.npc !== 32'h2004) begin bad++; $display("FAIL nt_npc: got %h want 2004", bus.npc); end
    total++; if (bus.mispredict !== 1'b1 || bus.redirect !== 1'b1) begin bad++; $display("FAIL nt_misp: got %b/%b want 1/1", bus.mispredict, bus.redirect); end
    bus.fetch_pc = 32'h2000;
    #1;
    total++; if (bus.btb_hit !== 1'b1 || bus.btb_target !== 32'h2040) begin bad++; $display("FAIL nt_btb_kept: got %b/%h want 1/2040", bus.btb_hit, bus.btb_target); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] e;
    logic [W:0] lk;
    bus.out_ready = 1'b0;
    drive_req(32'h5000, 32'h10, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h5010);
    m_commit();
    tick();
    // Stalled request that must not be taken until out_ready rises.
    drive_req(32'h5100, 32'h8, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    bus.fetch_pc = 32'h5100;
    #1;
    lk = m_lookup(32'h5100);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      total++; if (bus.out_valid !== 1'b1 || bus.branch_addr !== 32'h5010 || bus.npc !== 32'h5010)
        begin bad++; $display("FAIL bp_hold[%0d]: got %b/%h/%h want 1/5010/5010", i, bus.out_valid, bus.branch_addr, bus.npc); end
      total++; if (bus.btb_hit !== lk[W]) begin bad++; $display("FAIL bp_no_write[%0d]: got %b want %b", i, bus.btb_hit, lk[W]); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    m_commit();
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.branch_addr !== 32'h5108 || bus.mispredict !== 1'b1)
      begin bad++; $display("FAIL bp_release: got %b/%h/%b want 1/5108/1", bus.out_valid, bus.branch_addr, bus.mispredict); end
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      bus.in_valid = 1'b1;
      e = m_result_bus();
      m_commit();
      tick();
      total++; if (bus.out_valid !== 1'b1 || {bus.mispredict, bus.npc, bus.branch_addr} !== e)
        begin bad++; $display("FAIL b2b[%0d]: got %b %b/%h/%h want 1 %h", i, bus.out_valid, bus.mispredict, bus.npc, bus.branch_addr, e); end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    drive_req(32'h3000, 32'h100, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h3100);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.fetch_pc = 32'h3000;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.btb_hit !== 1'b0) begin bad++; $display("FAIL flush_no_btb: got %b want 0", bus.btb_hit); end
    // Flush also kills a result that is stalled downstream.
    bus.out_ready = 1'b0;
    drive_req(32'h3004, 32'h8, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_stalled: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_conflict();
    logic [W:0] lk;
    drive_req(32'h1000, 32'h40, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h1040);
    m_commit();
    tick();
    drive_req(32'h1020, 32'h80, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h10A0);
    bus.fetch_pc = 32'h1000;
    #1;
    lk = m_lookup(32'h1000);
    total++; if ({bus.btb_hit, bus.btb_target} !== lk) begin bad++; $display("FAIL conf_old_read: got %b/%h want %h", bus.btb_hit, bus.btb_target, lk); end
    m_commit();
    tick();
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.btb_hit !== 1'b0) begin bad++; $display("FAIL conf_evicted: got %b want 0", bus.btb_hit); end
    bus.fetch_pc = 32'h1020;
    #1;
    total++; if (bus.btb_hit !== 1'b1 || bus.btb_target !== 32'h10A0) begin bad++; $display("FAIL conf_new: got %b/%h want 1/10a0", bus.btb_hit, bus.btb_target); end
    tick();
  endtask

  task automatic test_reset_midop();
    bus.out_ready = 1'b0;
    drive_req(32'h6000, 32'h20, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h6020);
    tick();
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_btb_pc.delete(); m_btb_tgt.delete(); exp_q.delete();
    bus.out_ready = 1'b1;
    bus.fetch_pc = 32'h6000;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.btb_hit !== 1'b0) begin bad++; $display("FAIL midrst_btb: got %b want 0", bus.btb_hit); end
  endtask

  task automatic test_random();
    logic exp_ready, acc;
    logic [W:0] lk;
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.fetch_pc  = 32'h4000 + W'($urandom_range(0, 47)) * 4;
      #1;
      exp_ready = (exp_q.size() == 0) || bus.out_ready;
      lk = m_lookup(bus.fetch_pc);
      total++; if (bus.in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.in_ready, exp_ready); end
      total++; if (bus.out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        total++; if ({bus.mispredict, bus.npc, bus.branch_addr} !== exp_q[0] || bus.redirect !== exp_q[0][RW-1])
          begin bad++; $display("FAIL rnd_result[%0d]: got %b/%h/%h want %h", c, bus.mispredict, bus.npc, bus.branch_addr, exp_q[0]); end
      end
      total++; if ({bus.btb_hit, bus.btb_target} !== lk) begin bad++; $display("FAIL rnd_btb[%0d]: got %b/%h want %h", c, bus.btb_hit, bus.btb_target, lk); end
      acc = bus.in_valid && exp_ready && !bus.flush;
      if (bus.flush) exp_q.delete();
      else begin
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(m_result_bus());
      end
      if (acc) m_commit();
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pc_rel();
    test_reg_align_wrap();
    test_not_taken();
    test_back_to_back();
    test_flush();
    test_conflict();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
